requant_sat_pipe: RTL and testbench

- Parametrised, pipelined fixed-point requantiser: converts a signed 2N-bit product (2F fraction bits) to signed N-bit Q(M.F) (1 sign + M integer + F fraction).
- Selectable rounding mode, saturation with per-sample flag, and a saturation event counter.
- Valid/ready stream interface; sits between the multiplier array and the filter/accumulator datapath.

---
 rtl/requant_sat_pipe.sv | 116 +++++++++++
 tb/tb_requant_sat_pipe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/requant_sat_pipe.sv
// Two-stage requantiser: a signed 2N-bit product with 2F fraction bits is
// rounded to F fraction bits in stage 1, then clamped to signed N-bit Q(M.F)
// in stage 2. A single advance signal stalls the whole pipe when the
// downstream side holds off. Saturated samples that are delivered are counted
// in a sticky counter that stops at all-ones.
module requant_sat_pipe #(
  parameter int M  = 7,
  parameter int F  = 8,
  parameter int N  = 1 + M + F,
  parameter int CW = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_sat,
  output logic [CW-1:0]    sat_count,
  input  logic             clr_count
);

  // Sign-extended working width and the width left after dropping F bits.
  localparam int XW = 2*N + 1;
  localparam int SW = XW - F;

  localparam logic [F-1:0]          HALF = {1'b1, {(F-1){1'b0}}};
  localparam logic signed [SW-1:0]  MAXV = {{(SW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [SW-1:0]  MINV = {{(SW-N+1){1'b1}}, {(N-1){1'b0}}};

  logic                  adv;
  logic signed [XW-1:0]  x_next;
  logic signed [XW-1:0]  xs_next;
  logic [F-1:0]          d_next;
  logic                  inc_next;
  logic signed [SW-1:0]  s1_next;
  logic signed [SW-1:0]  s1_reg;
  logic                  v1_reg;
  logic [N-1:0]          sat_data_next;
  logic                  sat_flag_next;
  logic                  out_valid_reg;
  logic [N-1:0]          out_data_reg;
  logic                  out_sat_reg;
  logic [CW-1:0]         sat_count_reg;

  // Whole pipe moves together whenever the output register can be refilled.
  assign adv       = !out_valid_reg || out_ready;
  assign in_ready  = adv && !reset;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sat   = out_sat_reg;
  assign sat_count = sat_count_reg;

  // Stage 1 rounding: floor via arithmetic shift, plus a mode-dependent increment.
  always_comb begin
    x_next   = {in_data[2*N-1], in_data};
    d_next   = x_next[F-1:0];
    inc_next = 1'b0;
    case (in_mode)
      2'b01:   inc_next = d_next[F-1];
      2'b10:   inc_next = (d_next > HALF) || ((d_next == HALF) && x_next[F]);
      default: inc_next = 1'b0;
    endcase
    xs_next = x_next >>> F;
    s1_next = signed'(xs_next[SW-1:0] + {{(SW-1){1'b0}}, inc_next});
  end

  // Stage 2 saturation: clamp the rounded value (including any rounding carry).
  always_comb begin
    sat_data_next = s1_reg[N-1:0];
    sat_flag_next = 1'b0;
    if (s1_reg > MAXV) begin
      sat_data_next = {1'b0, {(N-1){1'b1}}};
      sat_flag_next = 1'b1;
    end else if (s1_reg < MINV) begin
      sat_data_next = {1'b1, {(N-1){1'b0}}};
      sat_flag_next = 1'b1;
    end
  end

  // Pipeline registers; payloads only load behind a valid so held data stays put.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_reg        <= 1'b0;
      s1_reg        <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sat_reg   <= 1'b0;
    end else if (adv) begin
      v1_reg        <= in_valid;
      out_valid_reg <= v1_reg;
      if (in_valid) begin
        s1_reg <= s1_next;
      end
      if (v1_reg) begin
        out_data_reg <= sat_data_next;
        out_sat_reg  <= sat_flag_next;
      end
    end
  end

  // Count delivered saturated samples; clear has priority, count sticks at max.
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_count_reg <= '0;
    end else if (clr_count) begin
      sat_count_reg <= '0;
    end else if (out_valid_reg && out_ready && out_sat_reg && (sat_count_reg != {CW{1'b1}})) begin
      sat_count_reg <= sat_count_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_requant_sat_pipe.sv
// Directed bench for requant_sat_pipe with a scoreboard queue: expected
// {sat, data} pairs are queued at input transfer and compared in order at
// output transfer. A second instance with a 3-bit counter shares the inputs.
module tb_requant_sat_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic [15:0] sat_count;
  logic        clr_count;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [15:0] s_out_data;
  logic        s_out_sat;
  logic [2:0]  s_sat_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [16:0] q[$];
  logic        prev_stall = 1'b0;
  logic [16:0] prev_out = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  requant_sat_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .sat_count(sat_count), .clr_count(clr_count)
  );

  requant_sat_pipe #(.CW(3)) dut_small (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_data(s_out_data), .out_sat(s_out_sat),
    .sat_count(s_sat_count), .clr_count(clr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Integer reference: floor division, remainder-driven rounding, then clamp.
  function automatic logic [16:0] model(input logic [31:0] d, input logic [1:0] m);
    longint v;
    longint fl;
    longint rem;
    longint r;
    v   = longint'(signed'(d));
    fl  = v >>> 8;
    rem = v - fl * 256;
    r   = fl;
    if (m == 2'b01 && rem >= 128) r = r + 1;
    if (m == 2'b10 && (rem > 128 || (rem == 128 && fl[0]))) r = r + 1;
    if (r > 32767)  return {1'b1, 16'h7fff};
    if (r < -32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  // Output monitor: in-order scoreboard compare plus hold-under-stall check.
  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {31'b0, out_valid}, 32'd1);
        chk("hold_data", {15'b0, out_sat, out_data}, {15'b0, prev_out});
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
        end else begin
          logic [16:0] e;
          e = q.pop_front();
          chk("out_sat_data", {15'b0, out_sat, out_data}, {15'b0, e});
          $display("out: data=%h sat=%b expected data=%h sat=%b", out_data, out_sat, e[15:0], e[16]);
        end
      end
      prev_stall <= (out_valid === 1'b1) && (out_ready === 1'b0);
      prev_out   <= {out_sat, out_data};
    end
  end

  task automatic send(input logic [31:0] d, input logic [1:0] m, input logic [16:0] e);
    int n;
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) chk("send_timeout", {31'b0, in_ready}, 32'd1);
    else q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic sendm(input logic [31:0] d, input logic [1:0] m);
    send(d, m, model(d, m));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_queue_empty", q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clr_count = 1'b1;
    @(posedge clk);
    #1;
    clr_count = 1'b0;
  endtask

  initial begin
    int t0;
    int t1;
    logic [31:0] r;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0;
    out_ready = 1'b1; clr_count = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", {16'b0, out_data}, 32'd0);
    chk("rst_out_sat", {31'b0, out_sat}, 32'd0);
    chk("rst_sat_count", {16'b0, sat_count}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Latency: out_valid exactly 2 cycles after the transfer
    send(32'h00018000, 2'b00, {1'b0, 16'h0180});
    chk("lat_1cyc_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_2cyc_valid", {31'b0, out_valid}, 32'd1);
    drain();

    // Truncation and rounding modes
    send(32'hFFFE8000, 2'b00, {1'b0, 16'hFE80});
    send(32'h00018080, 2'b00, {1'b0, 16'h0180});
    send(32'h00018080, 2'b11, {1'b0, 16'h0180});
    send(32'h00018080, 2'b01, {1'b0, 16'h0181});
    send(32'h00018080, 2'b10, {1'b0, 16'h0180});
    send(32'h00018180, 2'b01, {1'b0, 16'h0182});
    send(32'h00018180, 2'b10, {1'b0, 16'h0182});
    send(32'hFFFE7F80, 2'b00, {1'b0, 16'hFE7F});
    send(32'hFFFE7F80, 2'b01, {1'b0, 16'hFE80});
    // Saturation boundaries, including rounding carry into overflow
    send(32'h00800000, 2'b00, {1'b1, 16'h7FFF});
    send(32'hFF800000, 2'b00, {1'b0, 16'h8000});
    send(32'hFF7FFF00, 2'b00, {1'b1, 16'h8000});
    send(32'h007FFF80, 2'b00, {1'b0, 16'h7FFF});
    send(32'h007FFF80, 2'b01, {1'b1, 16'h7FFF});
    send(32'h007FFF80, 2'b10, {1'b1, 16'h7FFF});
    drain();

    // sat_count: 5 then 9 saturations; 3-bit instance sticks at 7
    pulse_clear();
    chk("count_cleared", {16'b0, sat_count}, 32'd0);
    for (int i = 0; i < 5; i++) send(32'h40000000 + i, 2'b00, {1'b1, 16'h7FFF});
    drain();
    chk("count_5", {16'b0, sat_count}, 32'd5);
    chk("count_small_5", {29'b0, s_sat_count}, 32'd5);
    for (int i = 0; i < 4; i++) send(32'h80000000 + i, 2'b01, {1'b1, 16'h8000});
    drain();
    chk("count_9", {16'b0, sat_count}, 32'd9);
    chk("count_small_sticks_7", {29'b0, s_sat_count}, 32'd7);

    // Saturating sample held under stall counts once
    pulse_clear();
    out_ready = 1'b0;
    send(32'h01000000, 2'b00, {1'b1, 16'h7FFF});
    repeat (4) begin @(posedge clk); #1; end
    chk("stall_valid_held", {31'b0, out_valid}, 32'd1);
    chk("stall_not_counted", {16'b0, sat_count}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_counted_once", {16'b0, sat_count}, 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    chk("stall_still_once", {16'b0, sat_count}, 32'd1);

    // Clear coincident with a saturating transfer
    out_ready = 1'b0;
    send(32'hF0000000, 2'b00, {1'b1, 16'h8000});
    @(posedge clk); #1;
    chk("clr_pending_valid", {31'b0, out_valid}, 32'd1);
    clr_count = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    chk("clr_wins", {16'b0, sat_count}, 32'd0);
    drain();

    // Backpressure: 6 samples, out_ready low 3 cycles mid-stream
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          r = $urandom;
          sendm({{8{r[23]}}, r[23:0]}, 2'(i % 3));
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Throughput with out_ready high: 8 samples on 8 consecutive cycles
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      r = $urandom;
      sendm({{7{r[24]}}, r[24:0]}, 2'($urandom_range(0, 3)));
    end
    t1 = cyc;
    chk("throughput_cycles", t1 - t0, 32'd8);
    drain();

    // Reset with two samples in flight
    send(32'h00800000, 2'b00, {1'b1, 16'h7FFF});
    send(32'h00018000, 2'b00, {1'b0, 16'h0180});
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("postrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("postrst_sat_count", {16'b0, sat_count}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("postrst_no_valid", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
